// File: rtl/cdb_arbiter_if.sv
// Common Data Bus arbiter interface.
// Bundles the producer handshakes (request/tag/value in, ready out) and the
// broadcast bus. The "master" modport is the producer/environment side and the
// "slave" modport is the arbiter itself.
interface cdb_arbiter_if #(
  parameter int TAG_W = 5,
  parameter int VAL_W = 32
);
  logic             in_flush;

  logic             in_request_add;
  logic             in_request_logic;
  logic             in_request_mul;
  logic             in_request_load;
  logic             in_request_store;

  logic [TAG_W-1:0] in_tag_add;
  logic [TAG_W-1:0] in_tag_logic;
  logic [TAG_W-1:0] in_tag_mul;
  logic [TAG_W-1:0] in_tag_load;
  logic [TAG_W-1:0] in_tag_store;

  logic [VAL_W-1:0] in_val_add;
  logic [VAL_W-1:0] in_val_logic;
  logic [VAL_W-1:0] in_val_mul;
  logic [VAL_W-1:0] in_val_load;
  logic [VAL_W-1:0] in_val_store;

  logic             out_ready_add;
  logic             out_ready_logic;
  logic             out_ready_mul;
  logic             out_ready_load;
  logic             out_ready_store;

  logic [4:0]       out_pending;
  logic             out_broadcast;
  logic [TAG_W-1:0] out_tag;
  logic [VAL_W-1:0] out_val;

  modport master (
    output in_flush,
    output in_request_add, in_request_logic, in_request_mul, in_request_load, in_request_store,
    output in_tag_add, in_tag_logic, in_tag_mul, in_tag_load, in_tag_store,
    output in_val_add, in_val_logic, in_val_mul, in_val_load, in_val_store,
    input  out_ready_add, out_ready_logic, out_ready_mul, out_ready_load, out_ready_store,
    input  out_pending, out_broadcast, out_tag, out_val
  );

  modport slave (
    input  in_flush,
    input  in_request_add, in_request_logic, in_request_mul, in_request_load, in_request_store,
    input  in_tag_add, in_tag_logic, in_tag_mul, in_tag_load, in_tag_store,
    input  in_val_add, in_val_logic, in_val_mul, in_val_load, in_val_store,
    output out_ready_add, out_ready_logic, out_ready_mul, out_ready_load, out_ready_store,
    output out_pending, out_broadcast, out_tag, out_val
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter for the Tomasulo datapath.
// Five producers (add=0, logic=1, mul=2, load=3, store=4) each own a one-entry
// holding slot filled through a valid/ready handshake. One full slot is
// granted per cycle and its result is broadcast from registered outputs.
// A slot granted this cycle may be refilled on the same edge.
// Optional feature: define CDB_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority add > logic > mul > load > store.
module cdb_arbiter #(
  parameter int               TAG_W       = 5,
  parameter int               VAL_W       = 32,
  parameter logic [TAG_W-1:0] INVALID_TAG = '1
) (
  input logic           clk,
  input logic           rst_n,
  cdb_arbiter_if.slave  bus
);

  localparam int N = 5;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [VAL_W-1:0] val_t;

  // Producer inputs gathered into indexable form.
  logic [N-1:0] req;
  tag_t         req_tag [N];
  val_t         req_val [N];

  // Slot state.
  logic [N-1:0] pending_q, pending_d;
  tag_t         slot_tag_q [N];
  val_t         slot_val_q [N];

  // Arbitration and handshake.
  logic [N-1:0] grant;
  logic [N-1:0] ready;
  logic [N-1:0] accept;
  tag_t         grant_tag;
  val_t         grant_val;

  // Registered broadcast stage.
  logic out_broadcast_q, out_broadcast_d;
  tag_t out_tag_q, out_tag_d;
  val_t out_val_q, out_val_d;

  // Pack the per-producer signals so the rest of the logic can loop.
  always_comb begin
    req        = {bus.in_request_store, bus.in_request_load, bus.in_request_mul,
                  bus.in_request_logic, bus.in_request_add};
    req_tag[0] = bus.in_tag_add;
    req_tag[1] = bus.in_tag_logic;
    req_tag[2] = bus.in_tag_mul;
    req_tag[3] = bus.in_tag_load;
    req_tag[4] = bus.in_tag_store;
    req_val[0] = bus.in_val_add;
    req_val[1] = bus.in_val_logic;
    req_val[2] = bus.in_val_mul;
    req_val[3] = bus.in_val_load;
    req_val[4] = bus.in_val_store;
  end

`ifdef CDB_ARB_RR_EN
  logic [2:0] ptr_q, ptr_d;
  logic       found;

  // Round-robin search starting one past the last granted source; a flush
  // suppresses the grant so the pointer is left untouched.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    grant = '0;
    found = 1'b0;
    ptr_d = ptr_q;
    if (!bus.in_flush) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (int'(ptr_q) + 1 + k) % N;
        if (!found && pending_q[idx]) begin
          grant[idx] = 1'b1;
          ptr_d      = 3'(idx);
          found      = 1'b1;
        end
      end
    end
  end

  // Pointer register; resets to the store index so add is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 3'd4;
    else        ptr_q <= ptr_d;
  end
`else
  logic found;

  // Fixed priority: the lowest-index full slot wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (!bus.in_flush) begin
      for (int k = 0; k < N; k++) begin
        if (!found && pending_q[k]) begin
          grant[k] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`endif

  // Handshake, slot next-state and selection of the granted result.
  always_comb begin
    ready     = bus.in_flush ? '0 : (~pending_q | grant);
    accept    = req & ready;
    pending_d = pending_q;
    grant_tag = '0;
    grant_val = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        grant_tag = grant_tag | slot_tag_q[i];
        grant_val = grant_val | slot_val_q[i];
      end
      if (bus.in_flush)
        pending_d[i] = 1'b0;
      else if (accept[i] && (req_tag[i] != INVALID_TAG))
        pending_d[i] = 1'b1;
      else if (grant[i])
        pending_d[i] = 1'b0;
    end
  end

  // Broadcast stage next-state: a grant drives the bus, otherwise the tag idles
  // at INVALID_TAG and the value holds.
  always_comb begin
    out_broadcast_d = |grant;
    out_tag_d       = (|grant) ? grant_tag : INVALID_TAG;
    out_val_d       = (|grant) ? grant_val : out_val_q;
  end

  // Control state: slot-full flags and the broadcast registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      pending_q       <= '0;
      out_broadcast_q <= 1'b0;
      out_tag_q       <= INVALID_TAG;
      out_val_q       <= '0;
    end else begin
      pending_q       <= pending_d;
      out_broadcast_q <= out_broadcast_d;
      out_tag_q       <= out_tag_d;
      out_val_q       <= out_val_d;
    end
  end

  // Slot payload capture on an accepted, valid-tag request.
  // NOTE: payload storage has no reset; pending_q alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (accept[i] && (req_tag[i] != INVALID_TAG)) begin
        slot_tag_q[i] <= req_tag[i];
        slot_val_q[i] <= req_val[i];
      end
    end
  end

  assign bus.out_ready_add   = ready[0];
  assign bus.out_ready_logic = ready[1];
  assign bus.out_ready_mul   = ready[2];
  assign bus.out_ready_load  = ready[3];
  assign bus.out_ready_store = ready[4];
  assign bus.out_pending     = pending_q;
  assign bus.out_broadcast   = out_broadcast_q;
  assign bus.out_tag         = out_tag_q;
  assign bus.out_val         = out_val_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter. Each scenario task drives stimulus and
// compares outputs 1 time unit after the rising edge against hand-computed values.
module tb_cdb_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  cdb_arbiter_if #(.TAG_W(5), .VAL_W(32)) bus ();

  cdb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one producer's request lines.
  task automatic set_req(input int i, input logic r, input logic [4:0] t, input logic [31:0] v);
    case (i)
      0: begin bus.in_request_add   = r; bus.in_tag_add   = t; bus.in_val_add   = v; end
      1: begin bus.in_request_logic = r; bus.in_tag_logic = t; bus.in_val_logic = v; end
      2: begin bus.in_request_mul   = r; bus.in_tag_mul   = t; bus.in_val_mul   = v; end
      3: begin bus.in_request_load  = r; bus.in_tag_load  = t; bus.in_val_load  = v; end
      default: begin bus.in_request_store = r; bus.in_tag_store = t; bus.in_val_store = v; end
    endcase
  endtask

  task automatic clear_inputs();
    bus.in_flush = 1'b0;
    for (int i = 0; i < 5; i++) set_req(i, 1'b0, 5'd0, 32'd0);
  endtask

  function automatic logic [4:0] ready_vec();
    return {bus.out_ready_store, bus.out_ready_load, bus.out_ready_mul,
            bus.out_ready_logic, bus.out_ready_add};
  endfunction

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.out_pending, bus.out_broadcast, bus.out_tag} !== {5'b0, 1'b0, 5'h1F}) begin
      $display("FAIL reset_ctrl: got pend=%b bc=%b tag=%h want pend=00000 bc=0 tag=1f",
               bus.out_pending, bus.out_broadcast, bus.out_tag);
      errors++;
    end
    checks++;
    if (bus.out_val !== 32'd0) begin
      $display("FAIL reset_val: got %h want 00000000", bus.out_val);
      errors++;
    end
    checks++;
    if (ready_vec() !== 5'b11111) begin
      $display("FAIL reset_ready: got %b want 11111", ready_vec());
      errors++;
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1'b1, 5'd3, 32'h0000_00AA);
    #1;
    checks++;
    if (bus.out_ready_add !== 1'b1) begin
      $display("FAIL single_ready: got %b want 1", bus.out_ready_add);
      errors++;
    end
    tick();  // edge 1: accepted
    set_req(0, 1'b0, 5'd0, 32'd0);
    checks++;
    if ({bus.out_pending, bus.out_broadcast} !== {5'b00001, 1'b0}) begin
      $display("FAIL single_accept: got pend=%b bc=%b want pend=00001 bc=0",
               bus.out_pending, bus.out_broadcast);
      errors++;
    end
    checks++;
    if (bus.out_ready_add !== 1'b1) begin
      $display("FAIL single_ready_grant: got %b want 1", bus.out_ready_add);
      errors++;
    end
    tick();  // edge 2: broadcast
    checks++;
    if ({bus.out_broadcast, bus.out_tag, bus.out_val} !== {1'b1, 5'd3, 32'hAA}) begin
      $display("FAIL single_bcast: got bc=%b tag=%h val=%h want bc=1 tag=03 val=000000aa",
               bus.out_broadcast, bus.out_tag, bus.out_val);
      errors++;
    end
    tick();  // edge 3: idle, value holds
    checks++;
    if ({bus.out_broadcast, bus.out_tag, bus.out_val, bus.out_pending} !== {1'b0, 5'h1F, 32'hAA, 5'b0}) begin
      $display("FAIL single_idle: got bc=%b tag=%h val=%h pend=%b want bc=0 tag=1f val=000000aa pend=00000",
               bus.out_broadcast, bus.out_tag, bus.out_val, bus.out_pending);
      errors++;
    end
  endtask

  // All five full at once drain in index order starting from add (ptr=4 after reset).
  task automatic test_contention();
    logic [4:0] exp_pend;
    do_reset();
    for (int i = 0; i < 5; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
    tick();
    clear_inputs();
    checks++;
    if (bus.out_pending !== 5'b11111) begin
      $display("FAIL all_pending: got %b want 11111", bus.out_pending);
      errors++;
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_pend = 5'b11111;
      exp_pend = exp_pend << (k + 1);
      checks++;
      if ({bus.out_broadcast, bus.out_tag, bus.out_val, bus.out_pending} !==
          {1'b1, 5'(k + 1), 32'h100 + 32'(k), exp_pend}) begin
        $display("FAIL drain_%0d: got bc=%b tag=%h val=%h pend=%b want bc=1 tag=%h val=%h pend=%b",
                 k, bus.out_broadcast, bus.out_tag, bus.out_val, bus.out_pending,
                 5'(k + 1), 32'h100 + 32'(k), exp_pend);
        errors++;
      end
    end
    tick();
    checks++;
    if (bus.out_broadcast !== 1'b0) begin
      $display("FAIL drain_done: got bc=%b want 0", bus.out_broadcast);
      errors++;
    end
  endtask

`ifdef CDB_ARB_RR_EN
  // Add and mul kept full: grants alternate add, mul, add, mul.
  task automatic test_rr_fairness();
    do_reset();
    set_req(0, 1'b1, 5'd10, 32'hA0);
    set_req(2, 1'b1, 5'd12, 32'hC0);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({bus.out_broadcast, bus.out_tag} !== {1'b1, (k % 2 == 0) ? 5'd10 : 5'd12}) begin
        $display("FAIL rr_alt_%0d: got bc=%b tag=%h want bc=1 tag=%h",
                 k, bus.out_broadcast, bus.out_tag, (k % 2 == 0) ? 5'd10 : 5'd12);
        errors++;
      end
    end
    clear_inputs();
  endtask
`else
  // Fixed priority: add refilled every cycle starves everyone else.
  task automatic test_starvation();
    do_reset();
    for (int i = 0; i < 5; i++) set_req(i, 1'b1, 5'(i + 1), 32'd0);
    tick();
    for (int i = 1; i < 5; i++) set_req(i, 1'b0, 5'd0, 32'd0);
    set_req(0, 1'b1, 5'd9, 32'h99);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({bus.out_broadcast, bus.out_tag, bus.out_pending} !==
          {1'b1, (k == 0) ? 5'd1 : 5'd9, 5'b11111}) begin
        $display("FAIL starve_%0d: got bc=%b tag=%h pend=%b want bc=1 tag=%h pend=11111",
                 k, bus.out_broadcast, bus.out_tag, bus.out_pending, (k == 0) ? 5'd1 : 5'd9);
        errors++;
      end
    end
    clear_inputs();
  endtask
`endif

  // Refill of the add slot on its own grant edge: tag 7 then tag 8.
  task automatic test_back_to_back();
    do_reset();
    set_req(0, 1'b1, 5'd7, 32'h77);
    tick();
    set_req(0, 1'b1, 5'd8, 32'h88);
    #1;
    checks++;
    if (bus.out_ready_add !== 1'b1) begin
      $display("FAIL refill_ready: got %b want 1", bus.out_ready_add);
      errors++;
    end
    tick();
    set_req(0, 1'b0, 5'd0, 32'd0);
    checks++;
    if ({bus.out_broadcast, bus.out_tag, bus.out_val, bus.out_pending} !== {1'b1, 5'd7, 32'h77, 5'b00001}) begin
      $display("FAIL refill_first: got bc=%b tag=%h val=%h pend=%b want bc=1 tag=07 val=00000077 pend=00001",
               bus.out_broadcast, bus.out_tag, bus.out_val, bus.out_pending);
      errors++;
    end
    tick();
    checks++;
    if ({bus.out_broadcast, bus.out_tag, bus.out_val, bus.out_pending} !== {1'b1, 5'd8, 32'h88, 5'b00000}) begin
      $display("FAIL refill_second: got bc=%b tag=%h val=%h pend=%b want bc=1 tag=08 val=00000088 pend=00000",
               bus.out_broadcast, bus.out_tag, bus.out_val, bus.out_pending);
      errors++;
    end
  endtask

  task automatic test_invalid_tag();
    do_reset();
    set_req(3, 1'b1, 5'h1F, 32'h55);
    #1;
    checks++;
    if (bus.out_ready_load !== 1'b1) begin
      $display("FAIL inv_ready: got %b want 1", bus.out_ready_load);
      errors++;
    end
    tick();
    set_req(3, 1'b0, 5'd0, 32'd0);
    checks++;
    if (bus.out_pending !== 5'b00000) begin
      $display("FAIL inv_pending: got %b want 00000", bus.out_pending);
      errors++;
    end
    tick();
    checks++;
    if ({bus.out_broadcast, bus.out_tag} !== {1'b0, 5'h1F}) begin
      $display("FAIL inv_bcast: got bc=%b tag=%h want bc=0 tag=1f", bus.out_broadcast, bus.out_tag);
      errors++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h1);
    set_req(2, 1'b1, 5'd2, 32'h2);
    set_req(4, 1'b1, 5'd4, 32'h4);
    tick();
    clear_inputs();
    bus.in_flush = 1'b1;
    set_req(1, 1'b1, 5'd6, 32'h6);
    set_req(3, 1'b1, 5'd9, 32'h9);
    #1;
    checks++;
    if (ready_vec() !== 5'b00000) begin
      $display("FAIL flush_ready: got %b want 00000", ready_vec());
      errors++;
    end
    tick();
    clear_inputs();
    checks++;
    if ({bus.out_pending, bus.out_broadcast, bus.out_tag} !== {5'b0, 1'b0, 5'h1F}) begin
      $display("FAIL flush_state: got pend=%b bc=%b tag=%h want pend=00000 bc=0 tag=1f",
               bus.out_pending, bus.out_broadcast, bus.out_tag);
      errors++;
    end
    tick();
    checks++;
    if ({bus.out_pending, bus.out_broadcast} !== {5'b0, 1'b0}) begin
      $display("FAIL flush_no_accept: got pend=%b bc=%b want pend=00000 bc=0",
               bus.out_pending, bus.out_broadcast);
      errors++;
    end
  endtask

  // Reset asserted between edges clears state without waiting for the clock.
  task automatic test_async_reset();
    do_reset();
    set_req(1, 1'b1, 5'd5, 32'h5);
    set_req(2, 1'b1, 5'd6, 32'h6);
    tick();
    clear_inputs();
    tick();  // logic broadcasting, mul still pending
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_pending, bus.out_broadcast, bus.out_tag, bus.out_val} !== {5'b0, 1'b0, 5'h1F, 32'd0}) begin
      $display("FAIL async_reset: got pend=%b bc=%b tag=%h val=%h want pend=00000 bc=0 tag=1f val=00000000",
               bus.out_pending, bus.out_broadcast, bus.out_tag, bus.out_val);
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
`ifdef CDB_ARB_RR_EN
    test_rr_fairness();
`else
    test_starvation();
`endif
    test_back_to_back();
    test_invalid_tag();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
